// File: rtl/maze_walk_ctrl_if.sv
// Signal bundle between the maze walk sequencer and its host, BFS solver and motor driver.
// master = the sequencer, slave = the environment around it.
interface maze_walk_ctrl_if;
    logic       walk_start;
    logic [3:0] start_x;
    logic [3:0] start_y;
    logic       grid_dirty;
    logic       bfs_start;
    logic [3:0] bfs_curr_x;
    logic [3:0] bfs_curr_y;
    logic       bfs_done;
    logic [6:0] bfs_dist;
    logic [1:0] bfs_next_dir;
    logic       bfs_next_valid;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic [6:0] step_count;
    logic       busy;
    logic       arrived;
    logic       fail;
    logic [1:0] fail_code;

    modport master (
        input  walk_start, start_x, start_y, grid_dirty,
        input  bfs_done, bfs_dist, bfs_next_dir, bfs_next_valid, move_ready,
        output bfs_start, bfs_curr_x, bfs_curr_y, move_valid, move_dir,
        output pos_x, pos_y, step_count, busy, arrived, fail, fail_code
    );

    modport slave (
        output walk_start, start_x, start_y, grid_dirty,
        output bfs_done, bfs_dist, bfs_next_dir, bfs_next_valid, move_ready,
        input  bfs_start, bfs_curr_x, bfs_curr_y, move_valid, move_dir,
        input  pos_x, pos_y, step_count, busy, arrived, fail, fail_code
    );
endinterface

// File: rtl/maze_walk_ctrl.sv
// Walk sequencer: launches the BFS solver, then steps the robot one cell per accepted move
// along bfs_next_dir until the goal, relaunching on grid changes and aborting on faults.
module maze_walk_ctrl #(
    parameter int GRID_W      = 10,
    parameter int GRID_H      = 10,
    parameter int BFS_TIMEOUT = 20000,
    parameter int MAX_STEPS   = 127
) (
    input logic             clk,
    input logic             rst,
    maze_walk_ctrl_if.master mw
);
    localparam int          TW           = $clog2(BFS_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(BFS_TIMEOUT - 1);
    localparam logic [6:0]  DIST_UNREACH = 7'h7F;
    localparam logic [1:0]  DIR_N = 2'd0, DIR_E = 2'd1, DIR_S = 2'd2, DIR_W = 2'd3;
    localparam logic [1:0]  FC_UNREACH = 2'b01, FC_TIMEOUT = 2'b10, FC_OVERRUN = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_BFS, S_SETTLE, S_EVAL, S_MOVE, S_ARRIVED, S_FAIL
    } state_t;

    state_t          state;
    logic [TW-1:0]   tmo_cnt;
    logic            dirty;
    logic            bfs_start_r;
    logic            move_valid_r;
    logic [1:0]      move_dir_r;
    logic [3:0]      pos_x_r;
    logic [3:0]      pos_y_r;
    logic [6:0]      step_r;
    logic            busy_r;
    logic            arrived_r;
    logic            fail_r;
    logic [1:0]      fail_code_r;

    // A direction that would leave the grid is treated like a step overrun, never issued.
    function automatic logic dir_oob(input logic [1:0] dir, input logic [3:0] x, input logic [3:0] y);
        case (dir)
            DIR_N:   return (y == 4'd0);
            DIR_E:   return (x == 4'(GRID_W - 1));
            DIR_S:   return (y == 4'(GRID_H - 1));
            default: return (x == 4'd0);
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            dirty        <= 1'b0;
            bfs_start_r  <= 1'b0;
            move_valid_r <= 1'b0;
            move_dir_r   <= 2'd0;
            pos_x_r      <= 4'd0;
            pos_y_r      <= 4'd0;
            step_r       <= 7'd0;
            busy_r       <= 1'b0;
            arrived_r    <= 1'b0;
            fail_r       <= 1'b0;
            fail_code_r  <= 2'b00;
        end else begin
            bfs_start_r <= 1'b0;
            if (busy_r && mw.grid_dirty) dirty <= 1'b1;
            case (state)
                S_IDLE, S_ARRIVED, S_FAIL: begin
                    if (mw.walk_start) begin
                        pos_x_r     <= mw.start_x;
                        pos_y_r     <= mw.start_y;
                        step_r      <= 7'd0;
                        fail_code_r <= 2'b00;
                        dirty       <= 1'b0;
                        bfs_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                        arrived_r   <= 1'b0;
                        fail_r      <= 1'b0;
                        state       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT_BFS;
                end
                S_WAIT_BFS: begin
                    if (mw.bfs_done) begin
                        state <= S_SETTLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        busy_r      <= 1'b0;
                        fail_r      <= 1'b1;
                        fail_code_r <= FC_TIMEOUT;
                        state       <= S_FAIL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                // Gives the solver a full cycle to look up the freshly registered query cell.
                S_SETTLE: state <= S_EVAL;
                S_EVAL: begin
                    if (dirty) begin
                        dirty       <= mw.grid_dirty;
                        bfs_start_r <= 1'b1;
                        state       <= S_LAUNCH;
                    end else if (mw.bfs_dist == 7'd0) begin
                        busy_r    <= 1'b0;
                        arrived_r <= 1'b1;
                        state     <= S_ARRIVED;
                    end else if (mw.bfs_dist == DIST_UNREACH || !mw.bfs_next_valid) begin
                        busy_r      <= 1'b0;
                        fail_r      <= 1'b1;
                        fail_code_r <= FC_UNREACH;
                        state       <= S_FAIL;
                    end else if (step_r == 7'(MAX_STEPS) ||
                                 dir_oob(mw.bfs_next_dir, pos_x_r, pos_y_r)) begin
                        busy_r      <= 1'b0;
                        fail_r      <= 1'b1;
                        fail_code_r <= FC_OVERRUN;
                        state       <= S_FAIL;
                    end else begin
                        move_dir_r   <= mw.bfs_next_dir;
                        move_valid_r <= 1'b1;
                        state        <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (mw.move_ready) begin
                        move_valid_r <= 1'b0;
                        step_r       <= step_r + 7'd1;
                        case (move_dir_r)
                            DIR_N:   pos_y_r <= pos_y_r - 4'd1;
                            DIR_E:   pos_x_r <= pos_x_r + 4'd1;
                            DIR_S:   pos_y_r <= pos_y_r + 4'd1;
                            default: pos_x_r <= pos_x_r - 4'd1;
                        endcase
                        state <= S_SETTLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mw.bfs_start  = bfs_start_r;
    assign mw.bfs_curr_x = pos_x_r;
    assign mw.bfs_curr_y = pos_y_r;
    assign mw.move_valid = move_valid_r;
    assign mw.move_dir   = move_dir_r;
    assign mw.pos_x      = pos_x_r;
    assign mw.pos_y      = pos_y_r;
    assign mw.step_count = step_r;
    assign mw.busy       = busy_r;
    assign mw.arrived    = arrived_r;
    assign mw.fail       = fail_r;
    assign mw.fail_code  = fail_code_r;
endmodule
